// File: rtl/glyph_draw_ctrl.sv
// Pixel-write sequencer for the ten word-row letter cells: arbitrates fill/erase requests and
// walks the 5x6 glyph of the granted cell. Optional underline row: define GLYPH_UNDERLINE_EN.
module glyph_draw_ctrl #(
    parameter logic [2:0]  FG_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR = 3'b000,
    parameter int unsigned X_BASE    = 17,
    parameter int unsigned Y_BASE    = 95,
    parameter int unsigned X_PITCH   = 14
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       fill_req,
    input  logic [4:0] fill_char,
    input  logic [3:0] fill_pos,
    output logic       fill_gnt,
    input  logic       erase_req,
    input  logic [3:0] erase_pos,
    output logic       erase_gnt,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef GLYPH_UNDERLINE_EN
    localparam logic [2:0] LAST_ROW = 3'd6;
`else
    localparam logic [2:0] LAST_ROW = 3'd5;
`endif

    logic [1:0]  state_q, state_d;
    logic        prio_erase_q, prio_erase_d;
    logic        erase_q, erase_d;
    logic [3:0]  pos_q, pos_d;
    logic [29:0] glyph_q, glyph_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        underline;

    function automatic logic [29:0] glyph_rom(input logic [4:0] c);
        unique case (c)
            5'd1:    glyph_rom = 30'b01110_10001_10001_11111_10001_10001;
            5'd2:    glyph_rom = 30'b11110_10001_11110_10001_10001_11110;
            5'd3:    glyph_rom = 30'b01111_10000_10000_10000_10000_01111;
            5'd4:    glyph_rom = 30'b11110_10001_10001_10001_10001_11110;
            5'd5:    glyph_rom = 30'b11111_10000_11110_10000_10000_11111;
            5'd6:    glyph_rom = 30'b11111_10000_11110_10000_10000_10000;
            5'd7:    glyph_rom = 30'b01111_10000_10011_10001_10001_01111;
            5'd8:    glyph_rom = 30'b10001_10001_11111_10001_10001_10001;
            5'd9:    glyph_rom = 30'b01110_00100_00100_00100_00100_01110;
            5'd10:   glyph_rom = 30'b00111_00010_00010_00010_10010_01100;
            5'd11:   glyph_rom = 30'b10001_10010_11100_10010_10001_10001;
            5'd12:   glyph_rom = 30'b10000_10000_10000_10000_10000_11111;
            5'd13:   glyph_rom = 30'b10001_11011_10101_10001_10001_10001;
            5'd14:   glyph_rom = 30'b10001_11001_10101_10011_10001_10001;
            5'd15:   glyph_rom = 30'b01110_10001_10001_10001_10001_01110;
            5'd16:   glyph_rom = 30'b11110_10001_10001_11110_10000_10000;
            5'd17:   glyph_rom = 30'b01110_10001_10001_10101_10010_01101;
            5'd18:   glyph_rom = 30'b11110_10001_10001_11110_10010_10001;
            5'd19:   glyph_rom = 30'b01111_10000_01110_00001_00001_11110;
            5'd20:   glyph_rom = 30'b11111_00100_00100_00100_00100_00100;
            5'd21:   glyph_rom = 30'b10001_10001_10001_10001_10001_01110;
            5'd22:   glyph_rom = 30'b10001_10001_10001_10001_01010_00100;
            5'd23:   glyph_rom = 30'b10001_10001_10001_10101_11011_10001;
            5'd24:   glyph_rom = 30'b10001_01010_00100_00100_01010_10001;
            5'd25:   glyph_rom = 30'b10001_01010_00100_00100_00100_00100;
            5'd26:   glyph_rom = 30'b11111_00010_00100_01000_10000_11111;
            default: glyph_rom = '0;
        endcase
    endfunction

    always_comb begin
        fill_gnt  = (state_q == S_IDLE) && fill_req && (!erase_req || !prio_erase_q);
        erase_gnt = (state_q == S_IDLE) && erase_req && (!fill_req || prio_erase_q);

        state_d      = state_q;
        prio_erase_d = prio_erase_q;
        erase_d      = erase_q;
        pos_d        = pos_q;
        glyph_d      = glyph_q;
        row_d        = row_q;
        col_d        = col_q;

        case (state_q)
            S_IDLE: begin
                if (fill_gnt || erase_gnt) begin
                    erase_d      = erase_gnt;
                    pos_d        = erase_gnt ? erase_pos : fill_pos;
                    glyph_d      = erase_gnt ? 30'd0 : glyph_rom(fill_char);
                    row_d        = 3'd0;
                    col_d        = 3'd0;
                    prio_erase_d = fill_gnt;
                    state_d      = (pos_d >= 4'd1 && pos_d <= 4'd10) ? S_DRAW : S_DONE;
                end
            end
            S_DRAW: begin
                // Glyph shifts left so bit 29 is always the pixel about to be emitted.
                glyph_d = glyph_q << 1;
                if (col_q == 3'd4) begin
                    col_d = 3'd0;
                    row_d = row_q + 3'd1;
                    if (row_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from next-state values so pixel 0 appears the cycle after grant.
        underline = (row_d == 3'd6);
        plot_d    = (state_d == S_DRAW);
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        if (plot_d) begin
            x_d = 8'(X_BASE) + 8'(X_PITCH) * (8'(pos_d) - 8'd1) + 8'(col_d);
            y_d = 7'(Y_BASE) + 7'(row_d) + (underline ? 7'd1 : 7'd0);
            colour_d = ((!erase_d && glyph_d[29]) || underline) ? FG_COLOUR : BG_COLOUR;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            prio_erase_q <= 1'b0;
            erase_q      <= 1'b0;
            pos_q        <= 4'd0;
            glyph_q      <= 30'd0;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            colour_q     <= 3'd0;
            plot_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_erase_q <= prio_erase_d;
            erase_q      <= erase_d;
            pos_q        <= pos_d;
            glyph_q      <= glyph_d;
            row_q        <= row_d;
            col_q        <= col_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;

endmodule

// File: tb/tb_glyph_draw_ctrl.sv
// Scoreboard bench for glyph_draw_ctrl; follows GLYPH_UNDERLINE_EN when defined.
module tb_glyph_draw_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       fill_req = 1'b0;
    logic [4:0] fill_char = 5'd0;
    logic [3:0] fill_pos = 4'd0;
    logic       fill_gnt;
    logic       erase_req = 1'b0;
    logic [3:0] erase_pos = 4'd0;
    logic       erase_gnt;
    logic       busy, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    glyph_draw_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .fill_req  (fill_req),
        .fill_char (fill_char),
        .fill_pos  (fill_pos),
        .fill_gnt  (fill_gnt),
        .erase_req (erase_req),
        .erase_pos (erase_pos),
        .erase_gnt (erase_gnt),
        .busy      (busy),
        .done      (done),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot)
    );

    always #5 clk = ~clk;

`ifdef GLYPH_UNDERLINE_EN
    localparam int NPIX = 35;
`else
    localparam int NPIX = 30;
`endif

    typedef struct {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference glyphs for the letters the bench draws.
    function automatic logic [29:0] ref_glyph(input int c);
        if (c == 1)  return 30'b011101000110001111111000110001;
        if (c == 26) return 30'b111110001000100010001000011111;
        return 30'd0;
    endfunction

    task automatic push_expected(input bit is_erase, input int ch, input int pos);
        logic [29:0] g;
        pix_t p;
        g = ref_glyph(ch);
        for (int r = 0; r < NPIX / 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                p.px = 8'(17 + 14 * (pos - 1) + c);
                if (r < 6) begin
                    p.py = 7'(95 + r);
                    p.pc = (!is_erase && g[29 - 5 * r - c]) ? 3'd7 : 3'd0;
                end else begin
                    p.py = 7'd102;
                    p.pc = 3'd7;
                end
                sb.push_back(p);
            end
        end
    endtask

    task automatic do_reset();
        fill_req  = 1'b0;
        erase_req = 1'b0;
        resetn    = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // abort_at >= 0 pulls resetn low while that pixel index is on the outputs.
    task automatic run_op(input bit is_erase, input int ch, input int pos, input int abort_at);
        logic got_gnt;
        int   npix;
        pix_t p;
        got_gnt = 1'b0;
        fill_char = 5'(ch);
        fill_pos  = 4'(pos);
        erase_pos = 4'(pos);
        fill_req  = !is_erase;
        erase_req = is_erase;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (is_erase ? erase_gnt : fill_gnt) begin
                got_gnt = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("grant", got_gnt, 1);
        if (!got_gnt) begin
            fill_req  = 1'b0;
            erase_req = 1'b0;
            return;
        end
        check("other_gnt", is_erase ? fill_gnt : erase_gnt, 0);
        npix = (pos >= 1 && pos <= 10) ? NPIX : 0;
        if (npix > 0) push_expected(is_erase, ch, pos);
        @(posedge clk);
        #1;
        fill_req  = 1'b0;
        erase_req = 1'b0;
        for (int k = 0; k < npix; k++) begin
            @(negedge clk);
            check("plot", plot, 1);
            check("done_early", done, 0);
            if (sb.size() > 0) begin
                p = sb.pop_front();
                check("x", x, p.px);
                check("y", y, p.py);
                check("colour", colour, p.pc);
            end
            if (k == abort_at) begin
                resetn = 1'b0;
                @(posedge clk);
                #1 resetn = 1'b1;
                @(negedge clk);
                check("abort_plot", plot, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_x", x, 0);
                sb.delete();
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("done", done, 1);
        check("done_plot", plot, 0);
        check("done_busy", busy, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g_cyc[4];
        bit g_erase[4];
        int n_g;
        int spacing;

        do_reset();
        @(negedge clk);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gnt", {fill_gnt, erase_gnt}, 0);
        check("rst_xyc", {x, y, colour}, 0);
        @(posedge clk);
        #1;

        run_op(0, 1, 1, -1);   // letter a in cell 1
        run_op(1, 0, 3, -1);   // erase cell 3
        run_op(0, 26, 10, -1); // letter z in cell 10
        run_op(0, 1, 0, -1);   // invalid positions
        run_op(0, 1, 11, -1);
        run_op(0, 0, 1, 12);   // blank glyph, aborted at pixel 12
        run_op(0, 1, 1, -1);   // fresh op after abort
`ifdef GLYPH_UNDERLINE_EN
        run_op(0, 1, 2, -1);
`endif

        // Both requesters held from reset: expect alternating grants.
        do_reset();
        fill_char = 5'd1;
        fill_pos  = 4'd1;
        erase_pos = 4'd2;
        fill_req  = 1'b1;
        erase_req = 1'b1;
        n_g = 0;
        for (int cyc = 0; cyc < 4 * (NPIX + 2) + 10; cyc++) begin
            @(negedge clk);
            if ((fill_gnt || erase_gnt) && n_g < 4) begin
                g_cyc[n_g]   = cyc;
                g_erase[n_g] = erase_gnt;
                n_g++;
            end
            @(posedge clk);
            #1;
        end
        fill_req  = 1'b0;
        erase_req = 1'b0;
        check("rr_count", n_g, 4);
        for (int i = 0; i < n_g; i++) begin
            check("rr_kind", g_erase[i], i % 2);
            if (i > 0) begin
                spacing = g_cyc[i] - g_cyc[i - 1];
                check("rr_spacing", spacing, NPIX + 2);
            end
        end
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/glyph_draw_ctrl.md
# glyph_draw_ctrl

Sequencer that owns the VGA pixel-write port for the ten letter cells of the word row. It arbitrates between a fill requester, which draws a letter, and an erase requester, which blanks a cell. It walks the granted cell's 5×6 glyph pixel by pixel and emits one (x, y, colour, plot) write per cycle to the VGA adapter. It sits between the game logic and the VGA adapter and replaces per-cell ad-hoc plotting.

## Interface
Parameters:
- FG_COLOUR, 3'b111, colour for set glyph bits
- BG_COLOUR, 3'b000, colour for clear bits and for erase
- X_BASE, 17, x of cell 1 top-left
- Y_BASE, 95, y of every cell's top row
- X_PITCH, 14, x distance between adjacent cells

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- fill_req  in  1  fill request, held until granted
- fill_char  in  5  letter code: 1=a … 26=z
- fill_pos  in  4  cell 1..10
- fill_gnt  out  1  one-cycle grant; request captured this cycle
- erase_req  in  1  erase request, held until granted
- erase_pos  in  4  cell 1..10
- erase_gnt  out  1  one-cycle grant
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when an operation completes
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour
- plot  out  1  write strobe for x/y/colour

## Operation
- States: IDLE, DRAW, DONE.
- IDLE:
  - Grants are combinational from state and requests.
  - If exactly one request is high, grant it.
  - If both are high, round-robin: grant the one not granted last. The priority flag resets to favour fill.
  - On the grant edge, capture the kind (fill/erase), pos, and 30-bit glyph from the internal ROM; clear row/col counters; go to DRAW.
- Glyph ROM: standard 5×6 font, bit 29 = top-left, row-major. Letter a = 30'b011101000110001111111000110001. char 0 or 27..31 gives all-zero (blank) glyph.
- DRAW:
  - Per cycle: x = X_BASE + X_PITCH·(pos−1) + col; y = Y_BASE + row; plot = 1.
  - Fill: colour = FG_COLOUR if glyph bit (29 − 5·row − col) is set, else BG_COLOUR. Erase: colour = BG_COLOUR.
  - col counts 0..4 then wraps and increments row. Leave DRAW after row 5, col 4.
- Invalid pos (0, 11..15): request is granted, no pixel is plotted, and the FSM goes straight to DONE.
- DONE: done = 1, plot = 0, busy = 1; next state IDLE.
- Address arithmetic: compute in 9 bits and truncate to 8. For legal pos, max x = 147.
- No grant is issued outside IDLE. Requests arriving during DRAW/DONE wait.

## Timing
- Grant at cycle G. Pixel 0 outputs are registered and valid in cycle G+1. Pixels 0..29 occupy G+1..G+30.
- done is high in G+31. Earliest next grant is G+32.
- Invalid pos: done in G+1, next grant G+2.
- plot is low in every cycle outside DRAW. x/y/colour hold their last values when plot = 0.
- Reset is synchronous and takes priority over everything, including mid-operation. The next cycle shows state IDLE, plot=0, busy=0, done=0, fill_gnt=erase_gnt=0, x=0, y=0, colour=0, counters 0, and priority set to fill. An interrupted draw is abandoned, not resumed.
- A requester must drop or change its request in the cycle after its grant. A still-high request is treated as new.

## Configuration
- GLYPH_UNDERLINE_EN defined: after the 30 glyph pixels, DRAW emits 5 more pixels at y = Y_BASE+7, col 0..4, with colour = FG_COLOUR for both fill and erase. This keeps the blank-slot marker visible. Pixels occupy G+1..G+35, done is in G+36.
- Undefined: no underline, 30 pixels, timing as above.

## Test plan
- Reset, then fill_req with char=1, pos=1:
  - fill_gnt in cycle G.
  - G+1: (17,95) colour 0. G+2: (18,95) colour 7.
  - G+30: (21,100) colour 7.
  - done at G+31. Exactly 30 plot cycles.
- Erase pos=3: 30 plots covering x 45..49 × y 95..100, all colour 0, then done.
- fill_req and erase_req both held continuously from reset: grants go fill, erase, fill, erase. Consecutive grants are 32 cycles apart.
- Fill char=26, pos=10: first pixel (143,95) colour 7, last pixel (147,100) colour 7. Fill pos=0 and pos=11: grant, no plot, done the next cycle.
- Fill char=0: 30 plots, all colour 0. resetn low at pixel 12: the next cycle shows plot=0, busy=0, done=0. A new fill then restarts at pixel 0 with no done from the aborted op.
- With GLYPH_UNDERLINE_EN: fill char=1, pos=2 gives 35 plots. The last five are (31..35,102) colour 7; done at G+36.
